// File: rtl/tlat_capture_ctrl.sv
// tlat_capture_ctrl: upstream driver for a bank of transparent latches.
// Accepts a word over valid/ready, drives it onto lat_d, waits one setup
// cycle, pulses lat_e for OPEN_CYCLES clocks (0 treated as 1), then reports
// out_valid until out_ack. Every latch-facing signal comes from a flop.
//
// Optional build macro: TLAT_CTRL_FAULT_EN adds stuck-at override registers
// on lat_e, out_valid, in_ready (outputs) and in_valid, out_ack (inputs).
// With REGISTER also defined, each fault site is announced at time 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream word available
//   in_ready   block can accept a word (IDLE only, decoded from state)
//   in_data    upstream word
//   lat_e      latch enable (registered)
//   lat_d      latch data (registered)
//   out_valid  capture complete, latch holds lat_d
//   out_ack    downstream consumed the capture
//   cap_count  completed handshakes, wraps modulo 2^CNT_WIDTH
module tlat_capture_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned OPEN_CYCLES = 2,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 lat_e,
  output logic [WIDTH-1:0]     lat_d,
  output logic                 out_valid,
  input  logic                 out_ack,
  output logic [CNT_WIDTH-1:0] cap_count
);

  localparam int unsigned OPEN_EFF = (OPEN_CYCLES == 0) ? 1 : OPEN_CYCLES;
  localparam int unsigned WIN_W    = (OPEN_EFF > 1) ? $clog2(OPEN_EFF) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t               state_q, state_d;
  logic                 lat_e_q, lat_e_d;
  logic [WIDTH-1:0]     lat_d_q, lat_d_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [CNT_WIDTH-1:0] cap_q, cap_d;
  logic                 in_ready_c;
  logic                 in_valid_i;
  logic                 out_ack_i;

`ifdef TLAT_CTRL_FAULT_EN
  logic stuck_0_lat_e     = 1'b0;
  logic stuck_1_lat_e     = 1'b0;
  logic stuck_0_out_valid = 1'b0;
  logic stuck_1_out_valid = 1'b0;
  logic stuck_0_in_ready  = 1'b0;
  logic stuck_1_in_ready  = 1'b0;
  logic stuck_0_in_valid  = 1'b0;
  logic stuck_1_in_valid  = 1'b0;
  logic stuck_0_out_ack   = 1'b0;
  logic stuck_1_out_ack   = 1'b0;

`ifdef REGISTER
  initial begin
    $display("register  %m.stuck_0_lat_e output");
    $display("register  %m.stuck_1_lat_e output");
    $display("register  %m.stuck_0_out_valid output");
    $display("register  %m.stuck_1_out_valid output");
    $display("register  %m.stuck_0_in_ready output");
    $display("register  %m.stuck_1_in_ready output");
    $display("register  %m.stuck_0_in_valid input");
    $display("register  %m.stuck_1_in_valid input");
    $display("register  %m.stuck_0_out_ack input");
    $display("register  %m.stuck_1_out_ack input");
  end
`endif

  // stuck-at-1 wins over stuck-at-0; outputs are overridden at the pin only
  assign in_valid_i = stuck_1_in_valid  ? 1'b1 : (stuck_0_in_valid  ? 1'b0 : in_valid);
  assign out_ack_i  = stuck_1_out_ack   ? 1'b1 : (stuck_0_out_ack   ? 1'b0 : out_ack);
  assign lat_e      = stuck_1_lat_e     ? 1'b1 : (stuck_0_lat_e     ? 1'b0 : lat_e_q);
  assign out_valid  = stuck_1_out_valid ? 1'b1 : (stuck_0_out_valid ? 1'b0 : out_valid_q);
  assign in_ready   = stuck_1_in_ready  ? 1'b1 : (stuck_0_in_ready  ? 1'b0 : in_ready_c);
`else
  assign in_valid_i = in_valid;
  assign out_ack_i  = out_ack;
  assign lat_e      = lat_e_q;
  assign out_valid  = out_valid_q;
  assign in_ready   = in_ready_c;
`endif

  assign lat_d     = lat_d_q;
  assign cap_count = cap_q;

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    lat_e_d     = lat_e_q;
    lat_d_d     = lat_d_q;
    out_valid_d = out_valid_q;
    win_d       = win_q;
    cap_d       = cap_q;
    in_ready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid_i) begin
          lat_d_d = in_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // lat_d has been stable for a full cycle before enable rises
        lat_e_d = 1'b1;
        win_d   = WIN_W'(OPEN_EFF - 1);
        state_d = OPEN;
      end
      OPEN: begin
        if (win_q == '0) begin
          lat_e_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      HOLD: begin
        if (out_ack_i) begin
          out_valid_d = 1'b0;
          cap_d       = cap_q + CNT_WIDTH'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset closes the latch immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_e_q     <= 1'b0;
      lat_d_q     <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_e_q     <= lat_e_d;
      lat_d_q     <= lat_d_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
      cap_q       <= cap_d;
    end
  end

endmodule
